// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder
// Purpose  : Frame-buffered convolutional encoder, m=3..6, n=2..6 outputs.
//            Tail-biting support: define CONV_ENCODER_TAIL_BITING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv_encoder (
    input  logic       clk_i,
    input  logic       rst_an_i,
    input  logic       rst_sync_i,
    input  logic       start_i,
    input  logic [7:0] frame_len_i,
    input  logic [1:0] register_num_i,
    input  logic [2:0] valid_polynomials_i,
    input  logic       tail_biting_en_i,
    input  logic [7:0] polynomial1_i,
    input  logic [7:0] polynomial2_i,
    input  logic [7:0] polynomial3_i,
    input  logic [7:0] polynomial4_i,
    input  logic [7:0] polynomial5_i,
    input  logic [7:0] polynomial6_i,
    input  logic       data_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic [5:0] code_o,
    output logic       code_valid_o,
    input  logic       code_ready_i,
    output logic       code_last_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_PRELOAD = 3'd2;
    localparam logic [2:0] S_ENCODE  = 3'd3;
    localparam logic [2:0] S_TAIL    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]   r_state;
    logic [7:0]   r_len;
    logic [7:0]   r_idx;
    logic [2:0]   r_m;
    logic [2:0]   r_n;
    logic [2:0]   r_tail_cnt;
    logic         r_tb;
    logic [6:1]   r_sr;
    logic [254:0] r_buf;

    logic         w_tb_sel;
    logic         w_last_idx;
    logic         w_cur_bit;
    logic [6:0]   w_mask;
    logic [6:0]   w_s;
    logic [6:1]   w_preload;
    logic [5:0]   w_code;
    logic [7:0]   w_poly [6];
    logic         w_unused_poly;

`ifdef CONV_ENCODER_TAIL_BITING_EN
    assign w_tb_sel = tail_biting_en_i;
`else
    logic w_unused_tb;
    assign w_unused_tb = tail_biting_en_i;
    assign w_tb_sel    = 1'b0;
`endif

    assign w_poly[0] = polynomial1_i;
    assign w_poly[1] = polynomial2_i;
    assign w_poly[2] = polynomial3_i;
    assign w_poly[3] = polynomial4_i;
    assign w_poly[4] = polynomial5_i;
    assign w_poly[5] = polynomial6_i;
    // Bit 7 can never be tapped since m tops out at 6.
    assign w_unused_poly = ^{polynomial1_i[7], polynomial2_i[7], polynomial3_i[7],
                             polynomial4_i[7], polynomial5_i[7], polynomial6_i[7]};

    assign w_last_idx = (r_idx == r_len - 8'd1);
    assign w_cur_bit  = (r_state == S_ENCODE) ? r_buf[r_idx] : 1'b0;
    assign w_mask     = 7'h7F >> (3'd6 - r_m);
    assign w_s        = {r_sr, w_cur_bit};

    always_comb begin
        w_preload = '0;
`ifdef CONV_ENCODER_TAIL_BITING_EN
        // Tail-biting seeds the register with the frame's final bits.
        for (int j = 1; j <= 6; j++) begin
            if (r_tb && (r_len >= 8'(j)))
                w_preload[j] = r_buf[r_len - 8'(j)];
        end
`endif
    end

    always_comb begin
        w_code = '0;
        for (int k = 0; k < 6; k++) begin
            if (3'(k) < r_n)
                w_code[k] = ^(w_poly[k][6:0] & w_mask & w_s);
        end
    end

    assign data_ready_o = (r_state == S_LOAD);
    assign code_valid_o = (r_state == S_ENCODE) || (r_state == S_TAIL);
    assign code_o       = code_valid_o ? w_code : 6'd0;
    assign code_last_o  = ((r_state == S_ENCODE) && r_tb && w_last_idx) ||
                          ((r_state == S_TAIL) && (r_tail_cnt == r_m - 3'd1));
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);

    // Frame buffer contents are don't-care across reset.
    always_ff @(posedge clk_i) begin
        if (data_ready_o && data_valid_i)
            r_buf[r_idx] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_state    <= S_IDLE;
            r_len      <= 8'd0;
            r_idx      <= 8'd0;
            r_m        <= 3'd0;
            r_n        <= 3'd0;
            r_tail_cnt <= 3'd0;
            r_tb       <= 1'b0;
            r_sr       <= '0;
        end else if (rst_sync_i) begin
            r_state    <= S_IDLE;
            r_len      <= 8'd0;
            r_idx      <= 8'd0;
            r_m        <= 3'd0;
            r_n        <= 3'd0;
            r_tail_cnt <= 3'd0;
            r_tb       <= 1'b0;
            r_sr       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && (frame_len_i != 8'd0)) begin
                        r_len   <= frame_len_i;
                        r_m     <= 3'(register_num_i) + 3'd3;
                        r_n     <= (valid_polynomials_i < 3'd2) ? 3'd2 :
                                   (valid_polynomials_i == 3'd7) ? 3'd6 : valid_polynomials_i;
                        r_tb    <= w_tb_sel;
                        r_idx   <= 8'd0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (data_valid_i) begin
                        if (w_last_idx) begin
                            r_idx   <= 8'd0;
                            r_state <= S_PRELOAD;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                S_PRELOAD: begin
                    r_sr    <= w_preload;
                    r_state <= S_ENCODE;
                end
                S_ENCODE: begin
                    if (code_ready_i) begin
                        r_sr <= {r_sr[5:1], w_cur_bit};
                        if (w_last_idx) begin
                            r_idx      <= 8'd0;
                            r_tail_cnt <= 3'd0;
                            r_state    <= r_tb ? S_DONE : S_TAIL;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                S_TAIL: begin
                    if (code_ready_i) begin
                        r_sr <= {r_sr[5:1], 1'b0};
                        if (r_tail_cnt == r_m - 3'd1)
                            r_state <= S_DONE;
                        else
                            r_tail_cnt <= r_tail_cnt + 3'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_encoder
// Purpose  : Directed self-checking bench for conv_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_encoder;

    logic       clk_i;
    logic       rst_an_i;
    logic       rst_sync_i;
    logic       start_i;
    logic [7:0] frame_len_i;
    logic [1:0] register_num_i;
    logic [2:0] valid_polynomials_i;
    logic       tail_biting_en_i;
    logic [7:0] polynomial1_i, polynomial2_i, polynomial3_i;
    logic [7:0] polynomial4_i, polynomial5_i, polynomial6_i;
    logic       data_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic [5:0] code_o;
    logic       code_valid_o;
    logic       code_ready_i;
    logic       code_last_o;
    logic       busy_o;
    logic       done_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] got_code [$];
    logic       got_last [$];
    logic       got_done;

    logic [5:0] exp_imp [7] = '{6'b000011, 6'b000001, 6'b000000, 6'b000011,
                                6'b000011, 6'b000010, 6'b000011};

    conv_encoder dut (
        .clk_i              (clk_i),
        .rst_an_i           (rst_an_i),
        .rst_sync_i         (rst_sync_i),
        .start_i            (start_i),
        .frame_len_i        (frame_len_i),
        .register_num_i     (register_num_i),
        .valid_polynomials_i(valid_polynomials_i),
        .tail_biting_en_i   (tail_biting_en_i),
        .polynomial1_i      (polynomial1_i),
        .polynomial2_i      (polynomial2_i),
        .polynomial3_i      (polynomial3_i),
        .polynomial4_i      (polynomial4_i),
        .polynomial5_i      (polynomial5_i),
        .polynomial6_i      (polynomial6_i),
        .data_i             (data_i),
        .data_valid_i       (data_valid_i),
        .data_ready_o       (data_ready_o),
        .code_o             (code_o),
        .code_valid_o       (code_valid_o),
        .code_ready_i       (code_ready_i),
        .code_last_o        (code_last_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_polys(input logic [7:0] a, b, c, d, e, f);
        polynomial1_i = a; polynomial2_i = b; polynomial3_i = c;
        polynomial4_i = d; polynomial5_i = e; polynomial6_i = f;
    endtask

    task automatic start_frame(input logic [7:0] len, input logic [1:0] rn,
                               input logic [2:0] vp, input logic tb);
        frame_len_i         = len;
        register_num_i      = rn;
        valid_polynomials_i = vp;
        tail_biting_en_i    = tb;
        start_i             = 1'b1;
        tick();
        start_i             = 1'b0;
    endtask

    task automatic send_bits(input int len, input logic [254:0] bits);
        for (int i = 0; i < len; i++) begin
            data_i       = bits[i];
            data_valid_i = 1'b1;
            tick();
        end
        data_valid_i = 1'b0;
    endtask

    task automatic collect(input int budget);
        got_done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done_o) begin
                got_done = 1'b1;
                break;
            end
            if (code_valid_o && code_ready_i) begin
                got_code.push_back(code_o);
                got_last.push_back(code_last_o);
            end
            tick();
        end
        if (got_done) tick();
    endtask

    task automatic test_reset();
        rst_an_i = 1'b0;
        tick();
        n_cmp++;
        if ({data_ready_o, code_o, code_valid_o, code_last_o, busy_o, done_o} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {data_ready_o, code_o, code_valid_o, code_last_o, busy_o, done_o});
        end
        rst_an_i = 1'b1;
        tick();
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_impulse();
        set_polys(8'h5B, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00);
        start_frame(8'd1, 2'd3, 3'd0, 1'b0);
        send_bits(1, 255'd1);
        n_cmp++;
        if (code_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL impulse_preload_valid: got %b expected 0", code_valid_o);
        end
        tick();
        n_cmp++;
        if (code_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL impulse_first_valid_latency: got %b expected 1", code_valid_o);
        end
        got_code.delete(); got_last.delete();
        collect(40);
        n_cmp++;
        if (got_code.size() !== 7) begin
            n_err++;
            $display("FAIL impulse_count: got %0d expected 7", got_code.size());
        end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (got_code[i] !== exp_imp[i] || got_last[i] !== (i == 6)) begin
                n_err++;
                $display("FAIL impulse_word%0d: got code %b last %b expected code %b last %b",
                         i, got_code[i], got_last[i], exp_imp[i], (i == 6));
            end
        end
        n_cmp++;
        if (got_done !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL impulse_done: got done %b busy %b expected 1 0", got_done, busy_o);
        end
    endtask

    task automatic test_tail_biting();
`ifdef CONV_ENCODER_TAIL_BITING_EN
        logic [5:0] exp_tb [6] = '{6'b11, 6'b11, 6'b11, 6'b11, 6'b11, 6'b11};
        int         n_exp = 6;
`else
        // Tail-biting request is ignored: ordinary zero-tail encoding of six ones.
        logic [5:0] exp_tb [12] = '{6'b11, 6'b10, 6'b10, 6'b01, 6'b10, 6'b00,
                                    6'b00, 6'b01, 6'b01, 6'b10, 6'b01, 6'b11};
        int         n_exp = 12;
`endif
        set_polys(8'h5B, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00);
        start_frame(8'd6, 2'd3, 3'd1, 1'b1);
        send_bits(6, 255'h3F);
        got_code.delete(); got_last.delete();
        collect(60);
        n_cmp++;
        if (got_code.size() !== n_exp || got_done !== 1'b1) begin
            n_err++;
            $display("FAIL tailbite_count: got %0d words done %b expected %0d words done 1",
                     got_code.size(), got_done, n_exp);
        end
        for (int i = 0; i < n_exp; i++) begin
            n_cmp++;
            if (got_code[i] !== exp_tb[i] || got_last[i] !== (i == n_exp - 1)) begin
                n_err++;
                $display("FAIL tailbite_word%0d: got code %b last %b expected code %b last %b",
                         i, got_code[i], got_last[i], exp_tb[i], (i == n_exp - 1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] hold;
        set_polys(8'h5B, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00);
        start_frame(8'd1, 2'd3, 3'd0, 1'b0);
        send_bits(1, 255'd1);
        tick();
        got_code.delete(); got_last.delete();
        for (int i = 0; i < 2; i++) begin
            got_code.push_back(code_o);
            got_last.push_back(code_last_o);
            tick();
        end
        code_ready_i = 1'b0;
        hold = {code_valid_o, code_o};
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({code_valid_o, code_o} !== hold || hold[6] !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold%0d: got %b expected %b", i, {code_valid_o, code_o}, hold);
            end
        end
        code_ready_i = 1'b1;
        collect(40);
        n_cmp++;
        if (got_code.size() !== 7 || got_done !== 1'b1) begin
            n_err++;
            $display("FAIL stall_count: got %0d done %b expected 7 done 1", got_code.size(), got_done);
        end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (got_code[i] !== exp_imp[i] || got_last[i] !== (i == 6)) begin
                n_err++;
                $display("FAIL stall_word%0d: got %b last %b expected %b last %b",
                         i, got_code[i], got_last[i], exp_imp[i], (i == 6));
            end
        end
    endtask

    task automatic test_short_memory();
        logic [5:0] exp_s [4] = '{6'b000011, 6'b000001, 6'b000001, 6'b000001};
        set_polys(8'hFF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        start_frame(8'd1, 2'd0, 3'd0, 1'b0);
        // Configuration must be held from the accepted start.
        register_num_i      = 2'd3;
        valid_polynomials_i = 3'd7;
        frame_len_i         = 8'd9;
        send_bits(1, 255'd1);
        got_code.delete(); got_last.delete();
        collect(40);
        n_cmp++;
        if (got_code.size() !== 4 || got_done !== 1'b1) begin
            n_err++;
            $display("FAIL m3_count: got %0d done %b expected 4 done 1", got_code.size(), got_done);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_code[i] !== exp_s[i] || got_last[i] !== (i == 3)) begin
                n_err++;
                $display("FAIL m3_word%0d: got %b last %b expected %b last %b",
                         i, got_code[i], got_last[i], exp_s[i], (i == 3));
            end
        end
    endtask

    task automatic test_output_count();
        logic [2:0] vps  [2] = '{3'd4, 3'd7};
        logic [5:0] msks [2] = '{6'b001111, 6'b111111};
        set_polys(8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03);
        for (int v = 0; v < 2; v++) begin
            start_frame(8'd1, 2'd0, vps[v], 1'b0);
            send_bits(1, 255'd1);
            got_code.delete(); got_last.delete();
            collect(40);
            n_cmp++;
            if (got_code.size() !== 4 || got_code[0] !== msks[v] || got_code[1] !== msks[v] ||
                got_code[2] !== 6'd0 || got_code[3] !== 6'd0) begin
                n_err++;
                $display("FAIL n_outputs_vp%0d: got %0d words first %b expected 4 words first %b",
                         vps[v], got_code.size(), got_code[0], msks[v]);
            end
        end
    endtask

    task automatic test_ignore_start();
        set_polys(8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        start_frame(8'd0, 2'd0, 3'd0, 1'b0);
        tick();
        n_cmp++;
        if (busy_o !== 1'b0 || data_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len_start: got busy %b ready %b expected 0 0", busy_o, data_ready_o);
        end
        start_frame(8'd1, 2'd0, 3'd0, 1'b0);
        frame_len_i = 8'd200;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        n_cmp++;
        if (data_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_load: got ready %b busy %b expected 1 1", data_ready_o, busy_o);
        end
        send_bits(1, 255'd1);
        tick();
        code_ready_i = 1'b0;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        code_ready_i = 1'b1;
        got_code.delete(); got_last.delete();
        collect(40);
        tick();
        n_cmp++;
        if (got_code.size() !== 4 || got_code[0] !== 6'b000011 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL start_while_busy: got %0d words first %b busy %b expected 4 words 000011 busy 0",
                     got_code.size(), got_code[0], busy_o);
        end
    endtask

    task automatic test_async_reset();
        logic [254:0] pat;
        pat = '1;
        set_polys(8'h5B, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00);
        start_frame(8'd100, 2'd3, 3'd0, 1'b0);
        send_bits(100, pat);
        tick(); tick(); tick();
        n_cmp++;
        if (code_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_abort_encode: got valid %b busy %b expected 1 1", code_valid_o, busy_o);
        end
        rst_an_i = 1'b0;
        #1;
        n_cmp++;
        if ({data_ready_o, code_o, code_valid_o, code_last_o, busy_o, done_o} !== 11'd0) begin
            n_err++;
            $display("FAIL async_abort_outputs: got %b expected 0",
                     {data_ready_o, code_o, code_valid_o, code_last_o, busy_o, done_o});
        end
        tick();
        rst_an_i = 1'b1;
        tick();
        start_frame(8'd1, 2'd3, 3'd0, 1'b0);
        send_bits(1, 255'd1);
        got_code.delete(); got_last.delete();
        collect(40);
        n_cmp++;
        if (got_code.size() !== 7 || got_done !== 1'b1) begin
            n_err++;
            $display("FAIL post_abort_count: got %0d done %b expected 7 done 1", got_code.size(), got_done);
        end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (got_code[i] !== exp_imp[i]) begin
                n_err++;
                $display("FAIL post_abort_word%0d: got %b expected %b", i, got_code[i], exp_imp[i]);
            end
        end
    endtask

    task automatic test_sync_reset();
        set_polys(8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        start_frame(8'd5, 2'd0, 3'd0, 1'b0);
        send_bits(2, 255'd3);
        rst_sync_i = 1'b1;
        tick();
        n_cmp++;
        if ({data_ready_o, code_o, code_valid_o, code_last_o, busy_o, done_o} !== 11'd0) begin
            n_err++;
            $display("FAIL sync_reset_outputs: got %b expected 0",
                     {data_ready_o, code_o, code_valid_o, code_last_o, busy_o, done_o});
        end
        rst_sync_i = 1'b0;
        tick();
        start_frame(8'd1, 2'd0, 3'd0, 1'b0);
        send_bits(1, 255'd1);
        got_code.delete(); got_last.delete();
        collect(40);
        n_cmp++;
        if (got_code.size() !== 4 || got_code[0] !== 6'b000011 || got_code[3] !== 6'b000001 ||
            got_last[3] !== 1'b1) begin
            n_err++;
            $display("FAIL post_sync_reset_frame: got %0d words first %b expected 4 words 000011",
                     got_code.size(), got_code[0]);
        end
    endtask

    initial begin
        rst_an_i = 1'b0; rst_sync_i = 1'b0; start_i = 1'b0;
        frame_len_i = 8'd0; register_num_i = 2'd0; valid_polynomials_i = 3'd0;
        tail_biting_en_i = 1'b0; data_i = 1'b0; data_valid_i = 1'b0; code_ready_i = 1'b1;
        set_polys(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        test_reset();
        test_impulse();
        test_tail_biting();
        test_backpressure();
        test_short_memory();
        test_output_count();
        test_ignore_start();
        test_async_reset();
        test_sync_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk_i (single clock) and rst_an_i (asynchronous, active-low reset).
REQ-002 SHALL have the following ports, in this order:
- clk_i  in  1  clock
- rst_an_i  in  1  async active-low reset
- rst_sync_i  in  1  synchronous reset, active-high
- start_i  in  1  pulse; begins a frame
- frame_len_i  in  8  information bits per frame, 1..255; 0 means start_i is ignored
- register_num_i  in  2  memory length m = register_num_i+3 (3..6)
- valid_polynomials_i  in  3  output count n; 0/1 give n=2, 7 gives n=6
- tail_biting_en_i  in  1  1 = tail-biting, 0 = zero-tail
- polynomial1_i..polynomial6_i  in  8 each  generators; bit 0 = current input, bit j = input delayed j
- data_i  in  1  information bit
- data_valid_i  in  1  input valid
- data_ready_o  out  1  input ready
- code_o  out  6  code word; bit k = output of polynomial k+1; bits >= n are 0
- code_valid_o  out  1  output valid
- code_ready_i  in  1  output ready
- code_last_o  out  1  final code word of frame
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse after last code word transfers
REQ-003 SHALL sample frame_len_i, register_num_i, valid_polynomials_i and tail_biting_en_i on an accepted start_i and hold them for the whole frame.
REQ-004 SHALL read polynomial inputs live; they must be static during a frame.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, PRELOAD, ENCODE, TAIL and DONE.
REQ-006 IDLE: start_i=1 with frame_len_i != 0 SHALL go to LOAD; start_i in any other state SHALL be ignored.
REQ-007 LOAD: data_ready_o=1; each data_valid_i&data_ready_o SHALL write buffer[idx] (255x1); after frame_len bits SHALL go to PRELOAD.
REQ-008 PRELOAD (1 cycle): tail-biting SHALL set shift-register element j (j=1..m) to buffer[L-j], using 0 where L-j<0; zero-tail SHALL clear it; SHALL go to ENCODE.
REQ-009 ENCODE: code_o[k] SHALL equal XOR over j=0..m of poly_{k+1}[j] & s_j, with s_0 the current buffer bit and s_j the shift element; poly bits above m SHALL be ignored.
REQ-010 ENCODE: the register SHALL shift and the index SHALL advance only on code_valid_o&code_ready_i; code_o and code_valid_o SHALL stay stable while code_ready_i=0.
REQ-011 After L words, ENCODE SHALL go to TAIL (zero-tail) or DONE (tail-biting).
REQ-012 TAIL SHALL emit m words with input 0, then go to DONE.
REQ-013 code_last_o SHALL be 1 only with the final word of a frame: word L+m for zero-tail, word L for tail-biting.
REQ-014 DONE SHALL pulse done_o for 1 cycle and return to IDLE; busy_o SHALL be 1 in every state except IDLE.
REQ-015 Throughput SHALL be one word per cycle with code_ready_i held 1; the first code_valid_o SHALL occur 2 cycles after the last input bit is accepted.

Reset
REQ-016 rst_an_i low or rst_sync_i high SHALL set IDLE, clear the shift register and counters, and drive data_ready_o, code_o, code_valid_o, code_last_o, busy_o and done_o to 0, including mid-frame; buffer contents are don't-care.
REQ-017 After reset release, the first accepted start_i SHALL begin a clean frame with no residue from an aborted frame.

Configuration
REQ-018 Macro CONV_ENCODER_TAIL_BITING_EN defined: tail-biting SHALL be supported as specified above.
REQ-019 Macro CONV_ENCODER_TAIL_BITING_EN undefined: tail_biting_en_i SHALL be ignored, every frame SHALL be zero-tail, and PRELOAD SHALL only clear the register.

Verification
REQ-020 Impulse test, zero-tail, m=6, n=2, polynomial1=0x5B, polynomial2=0x79, L=1, data=1 -> code_o[1:0] = 11,01,00,11,11,10,11; code_last_o on the 7th word; then done_o.
REQ-021 Tail-biting, same polynomials, L=6, all ones -> six words of 11, no tail words, code_last_o on the 6th word.
REQ-022 Backpressure: code_ready_i=0 for 3 cycles mid-ENCODE -> code_o and code_valid_o unchanged; after release the word sequence equals the unstalled run.
REQ-023 m=3, polynomial1=0xFF, polynomial2=0x01, L=1, data=1, zero-tail -> code_o[1:0] = 11,01,01,01; code_o[5:2]=0 throughout.
REQ-024 rst_an_i pulsed during ENCODE of an L=100 frame -> all outputs 0 immediately; the next frame matches a fresh-reset reference.
REQ-025 start_i with frame_len_i=0, and start_i asserted while busy_o=1 -> no state change and no extra code words.
